// File: rtl/obs_gen.sv
// obs_gen: POMDP observation sampler driven by an external uniform random word.
//
// Purpose
//   Draws a 1-bit observation for the current action.
//   There is no true-state input, so P(o=0|a) is taken as the mean of
//   observe[a][0][0] and observe[a][1][0], which assumes a uniform prior over
//   the two states. The observation is 1 when random >= P(o=0|a).
//   Each sample takes three clock edges: capture, average, compare. The
//   en_belief output then pulses for one cycle to start the belief-update stage.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset; aborts any sample in flight
//   en           in   level request for one sample, checked in IDLE on each edge
//   action       in   action index a; codes >= NUM_ACT are ignored
//   random       in   uniform random word, unsigned Q0.PW
//   observe      in   observe[a][s][o] = P(o|s,a), unsigned Q0.PW (o=1 entries unused)
//   observation  out  registered sampled observation; holds between samples
//   en_belief    out  one-cycle pulse when a new observation is valid
module obs_gen #(
    parameter int NUM_ACT = 3,
    parameter int NUM_ST  = 2,
    parameter int NUM_OBS = 2,
    parameter int PW      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic [1:0]                                    action,
    input  logic [PW-1:0]                                 random,
    input  logic [NUM_ACT-1:0][NUM_ST-1:0][NUM_OBS-1:0][PW-1:0] observe,
    output logic                                          observation,
    output logic                                          en_belief
);

    localparam logic [1:0] ACT_LIM = 2'(NUM_ACT);

    typedef enum logic [1:0] {IDLE, CALC, CMP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          cap;
    logic          calc;
    logic          cmp;
    logic [1:0]    action_q;
    logic [PW-1:0] random_q;
    logic [PW-1:0] p0_q;
    logic [PW:0]   sum;
    logic          unused_obs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Once started, a sample always completes; en only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (en && action < ACT_LIM) ? CALC : IDLE;
            CALC:    state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap  = (state == IDLE) && en && (action < ACT_LIM);
        calc = (state == CALC);
        cmp  = (state == CMP);
    end

    // The sum keeps a carry bit, so the right shift is the exact mean of the
    // two Q0.PW probabilities. The mean always fits back into PW bits.
    assign sum = {1'b0, observe[action_q][0][0]} + {1'b0, observe[action_q][1][0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            action_q    <= '0;
            random_q    <= '0;
            p0_q        <= '0;
            observation <= 1'b0;
            en_belief   <= 1'b0;
        end else begin
            if (cap) begin
                action_q <= action;
                random_q <= random;
            end
            if (calc) p0_q <= sum[PW:1];
            if (cmp) observation <= (random_q >= p0_q);
            en_belief <= cmp;
        end
    end

    // The o=1 probabilities are implied by P(0|s,a)+P(1|s,a)=1.
    // They are never read. They are folded here only so that no port bits dangle.
    always_comb begin
        unused_obs = sum[0];
        for (int a = 0; a < NUM_ACT; a++)
            for (int s = 0; s < NUM_ST; s++)
                unused_obs = unused_obs ^ (^observe[a][s][NUM_OBS-1]);
    end

endmodule

// File: tb/tb_obs_gen.sv
// tb_obs_gen: self-checking bench for obs_gen using a vector table and directed sequences.
module tb_obs_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [1:0] action;
    logic [15:0] random;
    logic [2:0][1:0][1:0][15:0] observe;
    logic observation;
    logic en_belief;

    int errors = 0;
    int checks = 0;

    obs_gen dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .action(action),
        .random(random),
        .observe(observe),
        .observation(observation),
        .en_belief(en_belief)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [15:0] p00;
        logic [15:0] p10;
        logic [15:0] rnd;
        logic        exp;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The request is applied at a negedge. It is captured at the next posedge (N).
    // After capture, action and random are scrambled to show they were latched.
    task automatic run_sample(input logic [1:0] a, input logic [15:0] rnd, input logic exp,
                              input string name);
        en = 1'b1;
        action = a;
        random = rnd;
        @(negedge clk);
        chk({name, " eb@N"}, 16'(en_belief), 16'd0);
        en = 1'b0;
        action = a ^ 2'b01;
        random = ~rnd;
        @(negedge clk);
        chk({name, " eb@N+1"}, 16'(en_belief), 16'd0);
        @(negedge clk);
        chk({name, " eb@N+2"}, 16'(en_belief), 16'd1);
        chk({name, " obs@N+2"}, 16'(observation), 16'(exp));
        @(negedge clk);
        chk({name, " eb@N+3"}, 16'(en_belief), 16'd0);
        chk({name, " hold@N+3"}, 16'(observation), 16'(exp));
    endtask

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{2'd2, 16'h8000, 16'h8000, 16'h9000, 1'b1};
        vecs[1]  = '{2'd2, 16'h8000, 16'h8000, 16'h7FFF, 1'b0};
        vecs[2]  = '{2'd1, 16'h4000, 16'hC000, 16'h8000, 1'b1};
        vecs[3]  = '{2'd1, 16'h4000, 16'hC000, 16'h7FFF, 1'b0};
        vecs[4]  = '{2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0};
        vecs[6]  = '{2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[7]  = '{2'd1, 16'h0001, 16'h0002, 16'h0000, 1'b0};
        vecs[8]  = '{2'd1, 16'h0001, 16'h0002, 16'h0001, 1'b1};
        vecs[9]  = '{2'd2, 16'hFFFF, 16'h0001, 16'h7FFF, 1'b0};
        vecs[10] = '{2'd2, 16'hFFFF, 16'h0001, 16'h8000, 1'b1};

        rst_n = 1'b0;
        en = 1'b0;
        action = 2'd0;
        random = 16'h0;
        // o=1 entries hold junk that must not influence anything.
        for (int a = 0; a < 3; a++)
            for (int s = 0; s < 2; s++) begin
                observe[a][s][0] = 16'h8000;
                observe[a][s][1] = 16'h1234 + 16'(a * 7 + s * 3);
            end
        repeat (2) @(negedge clk);
        chk("reset obs", 16'(observation), 16'd0);
        chk("reset eb", 16'(en_belief), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle eb", 16'(en_belief), 16'd0);

        for (int i = 0; i < 11; i++) begin
            for (int a = 0; a < 3; a++) begin
                observe[a][0][0] = 16'h5555;
                observe[a][1][0] = 16'h5555;
            end
            observe[vecs[i].a][0][0] = vecs[i].p00;
            observe[vecs[i].a][1][0] = vecs[i].p10;
            run_sample(vecs[i].a, vecs[i].rnd, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // An invalid action held with en must never start a sample.
        for (int a = 0; a < 3; a++) begin
            observe[a][0][0] = 16'h8000;
            observe[a][1][0] = 16'h8000;
        end
        run_sample(2'd2, 16'h9000, 1'b1, "preinv");
        en = 1'b1;
        action = 2'b11;
        random = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("inv eb%0d", k), 16'(en_belief), 16'd0);
            chk($sformatf("inv obs%0d", k), 16'(observation), 16'd1);
        end
        en = 1'b0;

        // With en held high, a sample starts every third edge.
        en = 1'b1;
        action = 2'd2;
        random = 16'h7FFF;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 8) en = 1'b0;
            chk($sformatf("b2b eb%0d", k), 16'(en_belief), 16'((k == 2) || (k == 5) || (k == 8)));
        end
        chk("b2b obs", 16'(observation), 16'd0);

        // A reset issued during CALC clears the outputs at once.
        // No pulse must follow for the aborted sample.
        run_sample(2'd2, 16'hF000, 1'b1, "prerst");
        en = 1'b1;
        action = 2'd2;
        random = 16'h0000;
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst obs", 16'(observation), 16'd0);
        chk("rst eb", 16'(en_belief), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("postrst eb%0d", k), 16'(en_belief), 16'd0);
        end
        run_sample(2'd2, 16'h9000, 1'b1, "postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
